// File: rtl/bcd7_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: glyph table,
// segment bit positions and the all-dark segment pattern.
package bcd7_scan_pkg;

    // Bit positions inside o_seg = {dp,g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Everything dark (segments are active-low)
    localparam logic [7:0] SEG_OFF     = 8'hFF;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    // Active-low g..a patterns for hex digits 0..F
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/bcd7_scan_decode.sv
// Nibble to active-low 7-segment glyph lookup (purely combinational).
module seg7_decode
    import bcd7_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] glyph_o
);

    // Table lookup into the shared glyph constants
    always_comb begin
        glyph_o = GLYPH[nib_i];
    end

endmodule

// File: rtl/bcd7_scan.sv
// Time-multiplexed 7-segment display scanner with tear-free frame buffering.
// New data is held in a pending buffer and only becomes visible at a frame
// wrap, so a frame never mixes old and new digits.
// Optional feature: define BCD7_SCAN_BLANK_EN to blank leading-zero digits.
module bcd7_scan
    import bcd7_scan_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter bit AN_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_load,
    output logic [DIGITS-1:0]     o_an,
    output logic [7:0]            o_seg,
    output logic                  o_frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   run_q, run_d;     // set by first tick; outputs dark until then
    logic                   tick, wrap;

    logic [DIGITS-1:0][3:0] pend_q, pend_d;
    logic [DIGITS-1:0]      pdp_q, pdp_d;
    logic                   pflag_q, pflag_d;
    logic [DIGITS-1:0][3:0] disp_q, disp_d;
    logic [DIGITS-1:0]      ddp_q, ddp_d;

    logic [DIGITS-1:0]      an_q, an_d;
    logic [7:0]             seg_q, seg_d;
    logic                   frame_q, frame_d;

    logic [3:0]             nib;
    logic [6:0]             glyph, glyph_sel;
    logic [DIGITS-1:0]      an_onehot;

    assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign wrap = tick && run_q && (idx_q == IDX_W'(DIGITS - 1));

    // Prescaler and digit index advance
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        run_d = run_q;
        idx_d = idx_q;
        if (tick) begin
            if (!run_q)    run_d = 1'b1;
            else if (wrap) idx_d = '0;
            else           idx_d = idx_q + IDX_W'(1);
        end
    end

    // Pending / display buffering; a load on the wrap cycle bypasses pending
    always_comb begin
        pend_d  = pend_q;
        pdp_d   = pdp_q;
        pflag_d = pflag_q;
        disp_d  = disp_q;
        ddp_d   = ddp_q;
        if (wrap) begin
            if (i_load) begin
                disp_d = i_data;
                ddp_d  = i_dp;
            end else if (pflag_q) begin
                disp_d = pend_q;
                ddp_d  = pdp_q;
            end
            pflag_d = 1'b0;
        end else if (i_load) begin
            pend_d  = i_data;
            pdp_d   = i_dp;
            pflag_d = 1'b1;
        end
    end

    assign nib = disp_q[idx_q];

    seg7_decode u_dec (
        .nib_i   (nib),
        .glyph_o (glyph)
    );

`ifdef BCD7_SCAN_BLANK_EN
    logic [DIGITS-1:0] blank;
    logic              lead;

    // Leading-zero mask: walk down from the top digit until a nonzero one
    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead     = lead && (disp_q[k] == 4'd0);
            blank[k] = lead;
        end
        glyph_sel = blank[idx_q] ? GLYPH_BLANK : glyph;
    end
`else
    assign glyph_sel = glyph;
`endif

    // Next values for the registered display outputs
    always_comb begin
        an_onehot = DIGITS'(1) << idx_q;
        an_d      = AN_OFF;
        seg_d     = SEG_OFF;
        if (run_q) begin
            an_d          = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
            seg_d[6:0]    = glyph_sel;
            seg_d[SEG_DP] = ~ddp_q[idx_q];
        end
        frame_d = wrap;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            run_q   <= 1'b0;
            pend_q  <= '0;
            pdp_q   <= '0;
            pflag_q <= 1'b0;
            disp_q  <= '0;
            ddp_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            pend_q  <= pend_d;
            pdp_q   <= pdp_d;
            pflag_q <= pflag_d;
            disp_q  <= disp_d;
            ddp_q   <= ddp_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign o_an    = an_q;
    assign o_seg   = seg_q;
    assign o_frame = frame_q;

endmodule

// File: doc/bcd7_scan.md
BCD7_SCAN -- requirements
Module: bcd7_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is driven (>=2).
REQ-003 SHALL have parameter AN_ACTIVE_LOW, default 1, meaning anode select polarity (1: 0 enables digit).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port i_data, input, 4*DIGITS, meaning hex nibble per digit; digit k = i_data[4k+3:4k].
REQ-007 SHALL have port i_dp, input, DIGITS, meaning decimal point request per digit (1 = lit).
REQ-008 SHALL have port i_load, input, 1, meaning capture i_data/i_dp into pending buffer.
REQ-009 SHALL have port o_an, output, DIGITS, meaning registered digit enables.
REQ-010 SHALL have port o_seg, output, 8, meaning registered {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-011 SHALL have port o_frame, output, 1, meaning one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick = count at REFRESH_DIV-1.
REQ-013 On tick, digit index SHALL increment; at DIGITS-1 it SHALL wrap to 0 and o_frame SHALL pulse in the following cycle.
REQ-014 o_an/o_seg SHALL update exactly 1 cycle after index change; exactly one o_an bit active at any time out of reset.
REQ-015 i_load high SHALL latch i_data/i_dp into pending registers and set pending flag; repeated loads overwrite pending.
REQ-016 Pending SHALL transfer to display registers only at frame wrap (tear-free), clearing the flag.
REQ-017 i_load coincident with frame wrap SHALL write i_data/i_dp straight to display registers, pending flag cleared.
REQ-018 Frame wrap with no pending data SHALL leave display registers unchanged.
REQ-019 Decoder SHALL map 0-F to standard hex glyphs; 0 -> g..a = 1000000, 8 -> 0000000, F -> 0001110.
REQ-020 DIGITS=1 SHALL keep index at 0 and pulse o_frame every tick.

Reset
REQ-021 Reset low SHALL asynchronously clear prescaler, index, pending flag, pending/display registers.
REQ-022 During reset, o_an SHALL be all inactive (all 1 when AN_ACTIVE_LOW=1, else all 0), o_seg = 8'hFF, o_frame = 0.
REQ-023 First active digit after reset release SHALL be digit 0, driven after the first tick.
REQ-024 Reset mid-frame SHALL discard pending data; no partial frame resumes.

Configuration
REQ-025 With BCD7_SCAN_BLANK_EN defined, leading-zero digits (from digit DIGITS-1 downward, stopping at first nonzero; digit 0 never blanked) SHALL drive g..a = 1111111, dp still per i_dp.
REQ-026 Without BCD7_SCAN_BLANK_EN, every digit SHALL show its glyph, zeros included; no blanking logic synthesised.

Structure
REQ-027 Shared package SHALL hold the 16-entry glyph constants, SEG_OFF = 8'hFF, and segment bit-order localparams.
REQ-028 Nibble-to-glyph decode SHALL be sub-module seg7_decode (combinational, 4-bit in, 7-bit active-low out); scan, buffering and output registers stay in bcd7_scan.

Verification (DIGITS=4, REFRESH_DIV=4, AN_ACTIVE_LOW=1)
REQ-029 Reset low -> o_an = 4'b1111, o_seg = 8'hFF, o_frame = 0; release -> o_an = 4'b1110 after first tick, then 1101, 1011, 0111, wrap.
REQ-030 Load i_data=16'h12AF, i_dp=4'b0001 mid-frame -> old data held to frame end; next frame digit0 o_seg = 8'h0E, digit3 o_seg = 8'hF9.
REQ-031 Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows only 2222; o_frame one cycle wide every 16 cycles.
REQ-032 i_load coincident with wrap, i_data=16'h0008 -> next frame digit0 o_seg = 8'h80; macro defined: digits 3..1 o_seg = 8'hFF; undefined: 8'hC0.
REQ-033 Reset asserted during pending load -> after release, display shows 0 (8'hC0 on each digit, macro undefined), pending discarded.
